nf_input_debounce: RTL and testbench



---
 rtl/nf_input_debounce.sv | 75 +++++++
 tb/tb_nf_input_debounce.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/nf_input_debounce.sv
// nf_input_debounce: per-channel 2-FF synchronizer and debouncer paced by one shared prescaler; define NF_DEBOUNCE_EDGE_EN to build the rise/fall pulse registers
module nf_input_debounce #(
  parameter int chn = 12,
  parameter int tick_div = 50000,
  parameter int smp_num = 16,
  parameter logic [chn-1:0] rst_val = '0
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [chn-1:0] raw_in,
  output logic [chn-1:0] db_out,
  output logic [chn-1:0] rise,
  output logic [chn-1:0] fall,
  output logic           busy
);
  localparam int pw = $clog2(tick_div);
  localparam int sw = $clog2(smp_num);
  localparam logic [pw-1:0] pre_max = pw'(tick_div - 1);
  localparam logic [sw-1:0] smp_max = sw'(smp_num - 1);
  logic [chn-1:0] meta_q, sync_q, db_q, db_d;
  logic [pw-1:0] pre_q, pre_d;
  logic [sw-1:0] smp_q [chn];
  logic [sw-1:0] smp_d [chn];
  logic tick;
  assign tick = pre_q == pre_max;
  assign pre_d = tick ? '0 : pre_q + pw'(1);
  assign db_out = db_q;
  assign busy = |(sync_q ^ db_q);
  // any cycle where sync agrees with db restarts qualification; ticks advance it, the last tick accepts
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < chn; i++) begin
      smp_d[i] = smp_q[i];
      if (sync_q[i] == db_q[i]) smp_d[i] = '0;
      else if (tick && smp_q[i] == smp_max) begin
        db_d[i] = sync_q[i];
        smp_d[i] = '0;
      end else if (tick) smp_d[i] = smp_q[i] + sw'(1);
    end
  end
  // synchronizer stages, free-running prescaler, sample counters and debounced level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= rst_val;
      sync_q <= rst_val;
      db_q <= rst_val;
      pre_q <= '0;
      for (int i = 0; i < chn; i++) smp_q[i] <= '0;
    end else begin
      meta_q <= raw_in;
      sync_q <= meta_q;
      db_q <= db_d;
      pre_q <= pre_d;
      for (int i = 0; i < chn; i++) smp_q[i] <= smp_d[i];
    end
  end
`ifdef NF_DEBOUNCE_EDGE_EN
  logic [chn-1:0] rise_q, fall_q;
  // edge pulses are registered next to db so they coincide with the first cycle of the new level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif
endmodule

// File: tb/tb_nf_input_debounce.sv
// tb_nf_input_debounce: scoreboard bench; expected db_out events queued at stimulus time, popped when db_out moves
module tb_nf_input_debounce;
  localparam logic [3:0] rv = 4'b0011;
`ifdef NF_DEBOUNCE_EDGE_EN
  localparam logic en = 1'b1;
`else
  localparam logic en = 1'b0;
`endif
  typedef struct {
    int   ch;
    logic val;
    int   lo;
    int   hi;
  } ev_t;
  logic clk = 0;
  logic resetn = 0;
  logic [3:0] raw_in = rv;
  logic [3:0] db_out, rise, fall;
  logic busy;
  logic [3:0] prev = rv;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int t_ev [4];
  ev_t q[$];
  nf_input_debounce #(.chn(4), .tick_div(4), .smp_num(3), .rst_val(rv)) dut (
    .clk(clk), .resetn(resetn), .raw_in(raw_in), .db_out(db_out),
    .rise(rise), .fall(fall), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int ch, input logic val, input int lo, input int hi);
    ev_t e;
    e.ch = ch;
    e.val = val;
    e.lo = lo;
    e.hi = hi;
    q.push_back(e);
  endtask
  task automatic drain(input string tag);
    for (int k = 0; k < 40 && q.size() > 0; k++) step();
    chk(tag, q.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask
  // monitor: every db_out move must match the head of the scoreboard
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_db", db_out, rv);
      chk("rst_edge", {rise, fall}, 0);
      chk("rst_busy", busy, 0);
      prev = db_out;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (db_out[i] !== prev[i]) begin
          if (q.size() == 0) chk("unexp_change", db_out[i], prev[i]);
          else begin
            ev_t e;
            e = q.pop_front();
            chk("ev_ch", i, e.ch);
            chk("ev_val", db_out[i], e.val);
            chk("ev_window", (cyc >= e.lo && cyc <= e.hi), 1);
            chk("ev_rise", rise[i], en & e.val);
            chk("ev_fall", fall[i], en & ~e.val);
            t_ev[i] = cyc;
          end
        end else if (rise[i] | fall[i]) chk("stray_edge", {rise[i], fall[i]}, 0);
      end
      prev = db_out;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    step(3);
    resetn = 1;
    for (int k = 0; k < 50; k++) begin
      step();
      chk("s1_busy", busy, 0);
      chk("s1_db", db_out, rv);
    end
    raw_in[2] = 1;
    n = cyc;
    push(2, 1, n + 11, n + 14);
    step();
    chk("s2_busy_pre", busy, 0);
    step();
    chk("s2_busy_sync", busy, 1);
    drain("s2_drain");
    chk("s2_db", db_out, 4'b0111);
    for (int r = 0; r < 10; r++) begin
      raw_in[0] = 0;
      step(2);
      chk("s3_busy_hi", busy, 1);
      step(3);
      raw_in[0] = 1;
      step(2);
      chk("s3_busy_lo", busy, 0);
      step(3);
    end
    chk("s3_db", db_out, 4'b0111);
    raw_in[1] = 0;
    raw_in[3] = 1;
    n = cyc;
    push(1, 0, n + 11, n + 14);
    push(3, 1, n + 11, n + 14);
    drain("s4_drain");
    chk("s4_same_cycle", t_ev[3], t_ev[1]);
    chk("s4_db", db_out, 4'b1101);
    raw_in = rv;
    n = cyc;
    push(1, 1, n + 11, n + 14);
    push(2, 0, n + 11, n + 14);
    push(3, 0, n + 11, n + 14);
    drain("restore_drain");
    chk("restore_db", db_out, rv);
    raw_in[2] = 1;
    step(6);
    chk("s5_busy_pre", busy, 1);
    resetn = 0;
    #1;
    chk("s5_async_db", db_out, rv);
    chk("s5_async_busy", busy, 0);
    step(3);
    resetn = 1;
    n = cyc;
    push(2, 1, n + 12, n + 12);
    drain("s5_drain");
    chk("s5_db", db_out, 4'b0111);
    step(20);
    chk("s5_final_db", db_out, 4'b0111);
    chk("s5_leftover", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
